// File: rtl/apb_bridge_ctrl_p_if.sv
// rtl/apb_bridge_ctrl_p_if.sv - AHB-Lite side and APB4 side signal bundle of the bridge
// slave = bridge view, master = bus/slave-model view.
interface apb_bridge_ctrl_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NSLV   = 4
);
  localparam int SW = DATA_W / 8;

  logic                     HSEL;
  logic [ADDR_W-1:0]        HADDR;
  logic [1:0]               HTRANS;
  logic                     HWRITE;
  logic [2:0]               HSIZE;
  logic [DATA_W-1:0]        HWDATA;
  logic                     HREADY;
  logic                     HREADYOUT;
  logic                     HRESP;
  logic [DATA_W-1:0]        HRDATA;

  logic [ADDR_W-1:0]        PADDR;
  logic [NSLV-1:0]          PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [DATA_W-1:0]        PWDATA;
  logic [SW-1:0]            PSTRB;
  logic [NSLV*DATA_W-1:0]   PRDATA;
  logic [NSLV-1:0]          PREADY;
  logic [NSLV-1:0]          PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_bridge_ctrl_p.sv
// rtl/apb_bridge_ctrl_p.sv - AHB-Lite to APB4 bridge, one transfer at a time to NSLV slaves
// All outputs are registered; their next values are derived from the next state.
module apb_bridge_ctrl_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input logic                HCLK,
  input logic                HRESET,
  apb_bridge_ctrl_p_if.slave bus
);
  localparam int SW = DATA_W / 8;
  localparam int LW = $clog2(SW);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [NSLV-1:0]     psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]       pstrb_q, pstrb_d;
  logic [NSLV-1:0]     sel_q, sel_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;

  logic [3:0]          idx;
  logic [NSLV-1:0]     idx_oh;
  logic [ADDR_W-1:0]   align_mask;
  logic                legal;
  logic [SW-1:0]       strb_calc;
  logic                pready_s, pslverr_s;
  logic [DATA_W-1:0]   prdata_s;
  logic                timeout_hit;

  assign idx = bus.HADDR[SLV_LSB+3:SLV_LSB];

  // An index with no matching one-hot bit (>= NSLV) is the decode error.
  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == 4'(i)) idx_oh[i] = 1'b1;
    end
  end

  always_comb begin
    align_mask = (ADDR_W'(1) << bus.HSIZE) - ADDR_W'(1);
    legal      = (bus.HSIZE <= 3'(LW)) && !(|(bus.HADDR & align_mask)) && (|idx_oh);
    case (bus.HSIZE)
      3'd0:    strb_calc = SW'(1) << bus.HADDR[LW-1:0];
      3'd1:    strb_calc = SW'(3) << bus.HADDR[LW-1:0];
      default: strb_calc = '1;
    endcase
  end

  always_comb begin
    pready_s  = |(bus.PREADY & sel_q);
    pslverr_s = |(bus.PSLVERR & sel_q);
    prdata_s  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) prdata_s = prdata_s | bus.PRDATA[i*DATA_W +: DATA_W];
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (int'(tcnt_q) == TIMEOUT - 1);

  always_comb begin
    state_d  = state_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    sel_d    = sel_q;
    tcnt_d   = tcnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.HSEL && bus.HTRANS[1] && bus.HREADY) begin
          if (!legal) begin
            state_d = S_ERR1;
          end else begin
            sel_d    = idx_oh;
            paddr_d  = bus.HADDR;
            pwrite_d = bus.HWRITE;
            pstrb_d  = bus.HWRITE ? strb_calc : '0;
            tcnt_d   = '0;
            state_d  = bus.HWRITE ? S_WDATA : S_SETUP;
          end
        end
      end
      S_WDATA: begin
        pwdata_d = bus.HWDATA;
        tcnt_d   = '0;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready_s) begin
          if (pslverr_s) begin
            hrdata_d = '0;
            state_d  = S_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = prdata_s;
            state_d = S_IDLE;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    hreadyout_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    psel_d      = ((state_d == S_SETUP) || (state_d == S_ACCESS)) ? sel_d : '0;
    penable_d   = (state_d == S_ACCESS);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      sel_q       <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      sel_q       <= sel_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
endmodule

// File: tb/tb_apb_bridge_ctrl_p.sv
// tb/tb_apb_bridge_ctrl_p.sv - directed and random transfers against a transaction-level bridge model
// Inputs are driven and outputs sampled on the falling edge.
module tb_apb_bridge_ctrl_p;
  logic HCLK;
  logic HRESET;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_hrdata = '0;

  apb_bridge_ctrl_p_if #(.DATA_W(32), .ADDR_W(32), .NSLV(4)) bus ();

  apb_bridge_ctrl_p #(
    .DATA_W(32), .ADDR_W(32), .NSLV(4), .SLV_LSB(12), .TIMEOUT(16)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.HSEL    = 1'b0;
    bus.HADDR   = '0;
    bus.HTRANS  = 2'b00;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'd0;
    bus.HWDATA  = '0;
    bus.HREADY  = 1'b1;
    bus.PRDATA  = '0;
    bus.PREADY  = '0;
    bus.PSLVERR = '0;
  endtask

  // One AHB transfer; the slave model answers after 'waits' wait states (>=16 never answers).
  task automatic xfer(input string tag, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int waits, input bit slverr, input logic [31:0] rdata);
    int          idx, n, low, acc, setup, exp_acc, exp_low;
    bit          legal, to, exp_err, bad_apb, last_resp;
    logic [3:0]  exp_strb, exp_psel, psel_or;

    idx   = int'(addr[15:12]);
    legal = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0) && (idx < 4);
    to    = legal && (waits >= 16);
    exp_acc  = !legal ? 0 : (to ? 16 : waits + 1);
    exp_err  = !legal || to || slverr;
    exp_low  = !legal ? 1 : (wr ? 1 : 0) + 1 + exp_acc + (exp_err ? 1 : 0);
    exp_psel = legal ? 4'(1 << idx) : 4'b0000;
    if (!wr)            exp_strb = 4'b0000;
    else if (size == 0) exp_strb = 4'(1 << (addr % 4));
    else if (size == 1) exp_strb = 4'(3 << (addr % 4));
    else                exp_strb = 4'b1111;
    if (legal && !to) begin
      if (slverr)   model_hrdata = '0;
      else if (!wr) model_hrdata = rdata;
    end

    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr;
    bus.HWRITE = wr; bus.HSIZE = size; bus.HREADY = 1'b1;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wdata;
    low = 0; acc = 0; setup = 0; psel_or = '0; bad_apb = 0; last_resp = 0;
    for (n = 0; n < 200; n++) begin
      if (bus.HREADYOUT === 1'b1) break;
      low++;
      last_resp = bus.HRESP;
      if (bus.PSEL != 0) begin
        psel_or |= bus.PSEL;
        if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PSTRB !== exp_strb) bad_apb = 1;
        if (wr && bus.PENABLE && bus.PWDATA !== wdata) bad_apb = 1;
        if (bus.PENABLE) acc++; else setup++;
      end
      bus.PREADY  = '0;
      bus.PSLVERR = '0;
      bus.PRDATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (idx < 4) begin
        bus.PRDATA[idx*32 +: 32] = rdata;
        if (bus.PENABLE && acc > waits) begin
          bus.PREADY[idx]  = 1'b1;
          bus.PSLVERR[idx] = slverr;
        end
      end
      @(negedge HCLK);
    end
    bus.PREADY = '0; bus.PSLVERR = '0;
    check({tag, ".done"},   64'(n < 200), 64'(1));
    check({tag, ".low"},    64'(low), 64'(exp_low));
    check({tag, ".err1"},   64'(last_resp), 64'(exp_err));
    check({tag, ".hresp"},  64'(bus.HRESP), 64'(exp_err));
    check({tag, ".psel"},   64'(psel_or), 64'(exp_psel));
    check({tag, ".setup"},  64'(setup), 64'(legal ? 1 : 0));
    check({tag, ".access"}, 64'(acc), 64'(exp_acc));
    check({tag, ".apb"},    64'(bad_apb), 64'(0));
    check({tag, ".hrdata"}, 64'(bus.HRDATA), 64'(model_hrdata));
    if (exp_err) begin
      @(negedge HCLK);
      check({tag, ".idle_resp"}, 64'({bus.HREADYOUT, bus.HRESP}), 64'(2'b10));
    end
  endtask

  initial begin
    int          ridx, roff, rwait;
    logic [31:0] raddr;

    idle_inputs();
    HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    check("rst.hreadyout", 64'(bus.HREADYOUT), 64'(1));
    check("rst.hresp",     64'(bus.HRESP), 64'(0));
    check("rst.hrdata",    64'(bus.HRDATA), 64'(0));
    check("rst.psel",      64'(bus.PSEL), 64'(0));
    check("rst.apb",       64'({bus.PENABLE, bus.PWRITE, bus.PSTRB}), 64'(0));
    check("rst.paddr",     64'(bus.PADDR), 64'(0));
    check("rst.pwdata",    64'(bus.PWDATA), 64'(0));
    HRESET = 1'b0;

    // Non-accepting cycles: BUSY, HREADY low, HSEL low.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HADDR = 32'h1000; bus.HSIZE = 3'd2;
    @(negedge HCLK);
    check("busy.noaccept", 64'({bus.HREADYOUT, bus.PSEL}), 64'(5'b10000));
    bus.HTRANS = 2'b10; bus.HREADY = 1'b0;
    @(negedge HCLK);
    check("hready0.noaccept", 64'({bus.HREADYOUT, bus.PSEL}), 64'(5'b10000));
    bus.HREADY = 1'b1; bus.HSEL = 1'b0;
    @(negedge HCLK);
    check("hsel0.noaccept", 64'({bus.HREADYOUT, bus.HRESP, bus.PSEL}), 64'(6'b100000));

    xfer("rd_cafe",  32'h0000_1004, 1'b0, 3'd2, 32'h0,          0,  1'b0, 32'hCAFE_F00D);
    xfer("wr_byte",  32'h0000_2003, 1'b1, 3'd0, 32'hAB00_0000,  2,  1'b0, 32'h0);
    xfer("rd_slverr",32'h0000_3000, 1'b0, 3'd2, 32'h0,          0,  1'b1, 32'h1234_5678);
    xfer("dec_err",  32'h0000_5000, 1'b0, 3'd2, 32'h0,          0,  1'b0, 32'h0);
    xfer("mis_half", 32'h0000_1001, 1'b1, 3'd1, 32'h5555_AAAA,  0,  1'b0, 32'h0);
    xfer("big_size", 32'h0000_0000, 1'b0, 3'd3, 32'h0,          0,  1'b0, 32'h0);
    xfer("wr_half",  32'h0000_0002, 1'b1, 3'd1, 32'h1357_0000,  1,  1'b0, 32'h0);
    xfer("timeout",  32'h0000_0008, 1'b0, 3'd2, 32'h0,          40, 1'b0, 32'hDEAD_BEEF);
    xfer("wr_slverr",32'h0000_2000, 1'b1, 3'd2, 32'h0BAD_0BAD,  1,  1'b1, 32'h0);

    // Reset while in ACCESS aborts the transfer.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0000_3000; bus.HWRITE = 1'b0; bus.HSIZE = 3'd2;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(negedge HCLK);
    @(negedge HCLK);
    check("rstacc.in_access", 64'({bus.PSEL, bus.PENABLE}), 64'(5'b10001));
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    model_hrdata = '0;
    check("rstacc.apb",  64'({bus.PSEL, bus.PENABLE}), 64'(0));
    check("rstacc.ahb",  64'({bus.HREADYOUT, bus.HRESP}), 64'(2'b10));
    check("rstacc.hrdata", 64'(bus.HRDATA), 64'(0));
    xfer("after_rst", 32'h0000_3010, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0F0F_1234);

    for (int t = 0; t < 40; t++) begin
      ridx  = $urandom_range(0, 5);
      roff  = $urandom_range(0, 7);
      raddr = ($urandom() & 32'hFFFF_0000) | 32'(ridx << 12) | 32'(roff);
      rwait = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
      xfer($sformatf("rnd%0d", t), raddr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
           $urandom(), rwait, ($urandom_range(0, 5) == 0), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
